dformat_decode_queue: RTL and testbench

DFORMAT_DECODE_QUEUE -- requirements
Module: dformat_decode_queue

---
 rtl/dformat_decode_queue.sv | 185 ++++++++++++++++++
 tb/tb_dformat_decode_queue.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dformat_decode_queue.sv
// D-format instruction decoder feeding a DEPTH-entry queue of decoded entries, with saturating statistics.
// Define DFORMAT_FP_EN to decode the floating-point load/store opcodes 48-55.
module dformat_decode_queue #(
  parameter int unsigned DEPTH            = 4,
  parameter int unsigned CNT_WIDTH        = 16,
  parameter int unsigned instructionWidth = 32
) (
  input  logic                        clock_i,
  input  logic                        reset_i,
  input  logic                        flush_i,
  input  logic                        valid_i,
  output logic                        ready_o,
  input  logic [instructionWidth-1:0] instruction_i,
  output logic                        valid_o,
  input  logic                        ready_i,
  output logic [5:0]                  opcode_o,
  output logic [4:0]                  reg1_o,
  output logic [4:0]                  reg2_o,
  output logic [1:0]                  reg1Use_o,
  output logic [1:0]                  reg2Use_o,
  output logic                        reg2ValOrZero_o,
  output logic [15:0]                 imm_o,
  output logic                        immFormat_o,
  output logic [1:0]                  shiftImmUpBytes_o,
  output logic [CNT_WIDTH-1:0]        decodedCount_o,
  output logic [CNT_WIDTH-1:0]        droppedCount_o,
  output logic                        stall_o
);

  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned MSB = instructionWidth - 1;

`ifdef DFORMAT_FP_EN
  localparam bit FP_EN = 1'b1;
`else
  localparam bit FP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {USE_IMM = 2'd0, USE_READ = 2'd1, USE_WRITE = 2'd2, USE_RW = 2'd3} use_e;

  typedef struct packed {
    logic       is_d;
    use_e       r1u;
    use_e       r2u;
    logic       zero;
    logic       fmt;
    logic [1:0] shift;
  } dec_t;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [4:0]  reg1;
    logic [4:0]  reg2;
    use_e        r1u;
    use_e        r2u;
    logic        zero;
    logic [15:0] imm;
    logic        fmt;
    logic [1:0]  shift;
  } entry_t;

  function automatic dec_t mk(input use_e a, input use_e b, input logic z,
                              input logic f, input logic [1:0] s);
    dec_t d;
    d.is_d  = 1'b1;
    d.r1u   = a;
    d.r2u   = b;
    d.zero  = z;
    d.fmt   = f;
    d.shift = s;
    return d;
  endfunction

  logic [5:0]    op;
  dec_t          dec;
  entry_t        entry;
  entry_t        head;
  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count, count_nx;
  logic          ready_q;
  logic          push, enq, drop, pop;
  logic [CNT_WIDTH-1:0] dec_cnt, drop_cnt;

  assign op = instruction_i[MSB -: 6];

  always_comb begin
    dec      = mk(USE_IMM, USE_IMM, 1'b0, 1'b0, 2'd0);
    dec.is_d = 1'b0;
    case (op)
      6'd32, 6'd34, 6'd40, 6'd42, 6'd46: dec = mk(USE_WRITE, USE_READ, 1'b1, 1'b1, 2'd0);
      6'd33, 6'd35, 6'd41, 6'd43:        dec = mk(USE_WRITE, USE_RW,   1'b0, 1'b1, 2'd0);
      6'd36, 6'd38, 6'd44, 6'd47:        dec = mk(USE_READ,  USE_READ, 1'b1, 1'b1, 2'd0);
      6'd37, 6'd39, 6'd45:               dec = mk(USE_READ,  USE_RW,   1'b0, 1'b1, 2'd0);
      6'd48, 6'd50: if (FP_EN) dec = mk(USE_WRITE, USE_READ, 1'b1, 1'b1, 2'd0);
      6'd49, 6'd51: if (FP_EN) dec = mk(USE_WRITE, USE_RW,   1'b0, 1'b1, 2'd0);
      6'd52, 6'd54: if (FP_EN) dec = mk(USE_READ,  USE_READ, 1'b1, 1'b1, 2'd0);
      6'd53, 6'd55: if (FP_EN) dec = mk(USE_READ,  USE_RW,   1'b0, 1'b1, 2'd0);
      6'd14:                             dec = mk(USE_WRITE, USE_READ, 1'b1, 1'b1, 2'd0);
      6'd15:                             dec = mk(USE_WRITE, USE_READ, 1'b1, 1'b1, 2'd2);
      6'd7, 6'd8, 6'd12, 6'd13:          dec = mk(USE_WRITE, USE_READ, 1'b0, 1'b1, 2'd0);
      6'd2, 6'd3, 6'd11:                 dec = mk(USE_IMM,   USE_READ, 1'b0, 1'b1, 2'd0);
      6'd10:                             dec = mk(USE_IMM,   USE_READ, 1'b0, 1'b0, 2'd0);
      6'd24, 6'd26, 6'd28:               dec = mk(USE_READ,  USE_WRITE, 1'b0, 1'b0, 2'd0);
      6'd25, 6'd27, 6'd29:               dec = mk(USE_READ,  USE_WRITE, 1'b0, 1'b0, 2'd2);
      default: ;
    endcase
  end

  always_comb begin
    entry.opcode = op;
    entry.reg1   = instruction_i[MSB-6 -: 5];
    entry.reg2   = instruction_i[MSB-11 -: 5];
    entry.r1u    = dec.r1u;
    entry.r2u    = dec.r2u;
    entry.zero   = dec.zero;
    entry.imm    = instruction_i[MSB-16 -: 16];
    entry.fmt    = dec.fmt;
    entry.shift  = dec.shift;
  end

  // Flush rejects the handshake outright, so a flushed push is neither queued nor counted.
  assign push    = valid_i & ready_q & ~flush_i;
  assign enq     = push & dec.is_d;
  assign drop    = push & ~dec.is_d;
  assign valid_o = (count != '0);
  assign pop     = valid_o & ready_i & ~flush_i;

  always_comb begin
    count_nx = count;
    case ({enq, pop})
      2'b10:   count_nx = count + (PW+1)'(1);
      2'b01:   count_nx = count - (PW+1)'(1);
      default: count_nx = count;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (enq) mem[wr_ptr] <= entry;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ready_q  <= 1'b1;
      dec_cnt  <= '0;
      drop_cnt <= '0;
    end else if (flush_i) begin
      count   <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      ready_q <= 1'b1;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count_nx;
      // DEPTH is a power of two: occupancy < DEPTH exactly when the top bit is clear.
      ready_q <= ~count_nx[PW];
      if (enq  && dec_cnt  != '1) dec_cnt  <= dec_cnt  + CNT_WIDTH'(1);
      if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + CNT_WIDTH'(1);
    end
  end

  always_comb begin
    head = '0;
    if (valid_o) head = mem[rd_ptr];
  end

  assign opcode_o          = head.opcode;
  assign reg1_o            = head.reg1;
  assign reg2_o            = head.reg2;
  assign reg1Use_o         = head.r1u;
  assign reg2Use_o         = head.r2u;
  assign reg2ValOrZero_o   = head.zero;
  assign imm_o             = head.imm;
  assign immFormat_o       = head.fmt;
  assign shiftImmUpBytes_o = head.shift;
  assign ready_o           = ready_q;
  assign stall_o           = ~ready_q;
  assign decodedCount_o    = dec_cnt;
  assign droppedCount_o    = drop_cnt;

endmodule

// File: tb/tb_dformat_decode_queue.sv
// Self-checking bench for dformat_decode_queue against a queue-based reference model.
module tb_dformat_decode_queue;

  localparam int DEPTH = 4;
  localparam int SAT   = 65535;

  logic        clk = 1'b0;
  logic        reset_i = 1'b0, flush_i = 1'b0, valid_i = 1'b0, ready_i = 1'b0;
  logic [31:0] instruction_i = '0;
  logic        ready_o, valid_o, reg2ValOrZero_o, immFormat_o, stall_o;
  logic [5:0]  opcode_o;
  logic [4:0]  reg1_o, reg2_o;
  logic [1:0]  reg1Use_o, reg2Use_o, shiftImmUpBytes_o;
  logic [15:0] imm_o, decodedCount_o, droppedCount_o;

  always #5 clk = ~clk;

  dformat_decode_queue #(.DEPTH(DEPTH), .CNT_WIDTH(16), .instructionWidth(32)) dut (
    .clock_i(clk), .reset_i(reset_i), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
    .instruction_i(instruction_i), .valid_o(valid_o), .ready_i(ready_i), .opcode_o(opcode_o),
    .reg1_o(reg1_o), .reg2_o(reg2_o), .reg1Use_o(reg1Use_o), .reg2Use_o(reg2Use_o),
    .reg2ValOrZero_o(reg2ValOrZero_o), .imm_o(imm_o), .immFormat_o(immFormat_o),
    .shiftImmUpBytes_o(shiftImmUpBytes_o), .decodedCount_o(decodedCount_o),
    .droppedCount_o(droppedCount_o), .stall_o(stall_o)
  );

  typedef struct packed {
    logic is_d; logic [1:0] u1, u2; logic z, f; logic [1:0] s;
  } cls_t;

  typedef struct packed {
    logic valid, ready, stall;
    logic [5:0] opcode; logic [4:0] r1, r2; logic [1:0] u1, u2; logic z;
    logic [15:0] imm; logic f; logic [1:0] s; logic [15:0] dcnt, xcnt;
  } out_t;

  logic [31:0] mq[$];
  int          m_dec = 0, m_drop = 0;
  bit          m_ready = 1'b1;
  int          n_cmp = 0, n_fail = 0;
  out_t        o, e;

`ifdef DFORMAT_FP_EN
  localparam bit FP = 1'b1;
`else
  localparam bit FP = 1'b0;
`endif

  function automatic cls_t mkc(input bit d, input int a, input int b, input bit z, input bit f, input int s);
    cls_t c;
    c.is_d = d; c.u1 = 2'(a); c.u2 = 2'(b); c.z = z; c.f = f; c.s = 2'(s);
    return c;
  endfunction

  // Opcode classes straight from the decode table; uses: 0=imm 1=R 2=W 3=RW.
  function automatic cls_t spec_decode(input logic [5:0] op);
    if (op inside {32, 34, 40, 42, 46} || (FP && op inside {48, 50})) return mkc(1, 2, 1, 1, 1, 0);
    if (op inside {33, 35, 41, 43}     || (FP && op inside {49, 51})) return mkc(1, 2, 3, 0, 1, 0);
    if (op inside {36, 38, 44, 47}     || (FP && op inside {52, 54})) return mkc(1, 1, 1, 1, 1, 0);
    if (op inside {37, 39, 45}         || (FP && op inside {53, 55})) return mkc(1, 1, 3, 0, 1, 0);
    if (op == 14) return mkc(1, 2, 1, 1, 1, 0);
    if (op == 15) return mkc(1, 2, 1, 1, 1, 2);
    if (op inside {7, 8, 12, 13}) return mkc(1, 2, 1, 0, 1, 0);
    if (op inside {2, 3, 11}) return mkc(1, 0, 1, 0, 1, 0);
    if (op == 10) return mkc(1, 0, 1, 0, 0, 0);
    if (op inside {24, 26, 28}) return mkc(1, 1, 2, 0, 0, 0);
    if (op inside {25, 27, 29}) return mkc(1, 1, 2, 0, 0, 2);
    return mkc(0, 0, 0, 0, 0, 0);
  endfunction

  function automatic out_t model_out();
    out_t r;
    cls_t c;
    logic [31:0] w;
    r = '0;
    r.ready = m_ready; r.stall = !m_ready;
    r.dcnt = 16'(m_dec); r.xcnt = 16'(m_drop);
    if (mq.size() > 0) begin
      w = mq[0];
      c = spec_decode(w[31:26]);
      r.valid = 1'b1; r.opcode = w[31:26]; r.r1 = w[25:21]; r.r2 = w[20:16]; r.imm = w[15:0];
      r.u1 = c.u1; r.u2 = c.u2; r.z = c.z; r.f = c.f; r.s = c.s;
    end
    return r;
  endfunction

  function automatic out_t dut_out();
    out_t r;
    r.valid = valid_o; r.ready = ready_o; r.stall = stall_o; r.opcode = opcode_o;
    r.r1 = reg1_o; r.r2 = reg2_o; r.u1 = reg1Use_o; r.u2 = reg2Use_o; r.z = reg2ValOrZero_o;
    r.imm = imm_o; r.f = immFormat_o; r.s = shiftImmUpBytes_o;
    r.dcnt = decodedCount_o; r.xcnt = droppedCount_o;
    return r;
  endfunction

  // Drive one cycle of inputs and advance the reference model across the edge.
  task automatic step(input bit v, input logic [31:0] ins, input bit rdy, input bit fl, input bit rst);
    bit acc, popd;
    valid_i = v; instruction_i = ins; ready_i = rdy; flush_i = fl; reset_i = rst;
    @(posedge clk);
    if (rst) begin
      mq.delete(); m_dec = 0; m_drop = 0; m_ready = 1'b1;
    end else if (fl) begin
      mq.delete(); m_ready = 1'b1;
    end else begin
      acc  = v && m_ready;
      popd = (mq.size() > 0) && rdy;
      if (popd) void'(mq.pop_front());
      if (acc) begin
        if (spec_decode(ins[31:26]).is_d) begin
          mq.push_back(ins);
          if (m_dec < SAT) m_dec++;
        end else if (m_drop < SAT) m_drop++;
      end
      m_ready = (mq.size() < DEPTH);
    end
    #1;
  endtask

  function automatic logic [31:0] rand_ins(input int op);
    logic [31:0] r;
    r = $urandom();
    return {6'(op), r[25:0]};
  endfunction

  task automatic test_reset();
    out_t z;
    step(0, '0, 0, 0, 1);
    z = '0; z.ready = 1'b1;
    o = dut_out();
    n_cmp++;
    if (o !== z) begin n_fail++; $display("FAIL reset_state: got %h expected %h", o, z); end
    step(0, '0, 0, 0, 0);
  endtask

  task automatic test_addi();
    step(1, 32'h3861FFFC, 1, 0, 0);
    n_cmp++;
    if ({valid_o, reg1_o, reg2_o, imm_o, reg1Use_o, reg2Use_o, reg2ValOrZero_o, immFormat_o,
         shiftImmUpBytes_o, decodedCount_o} !==
        {1'b1, 5'd3, 5'd1, 16'hFFFC, 2'd2, 2'd1, 1'b1, 1'b1, 2'd0, 16'd1}) begin
      n_fail++;
      $display("FAIL addi_decode: got v=%b r1=%0d r2=%0d imm=%h use=%0d,%0d z=%b f=%b s=%0d dc=%0d expected v=1 r1=3 r2=1 imm=fffc use=2,1 z=1 f=1 s=0 dc=1",
               valid_o, reg1_o, reg2_o, imm_o, reg1Use_o, reg2Use_o, reg2ValOrZero_o, immFormat_o,
               shiftImmUpBytes_o, decodedCount_o);
    end
    step(0, '0, 1, 0, 0);
    o = dut_out(); e = model_out(); n_cmp++;
    if (o !== e) begin n_fail++; $display("FAIL addi_drain: got %h expected %h", o, e); end
  endtask

  task automatic test_fill_drain();
    logic [31:0] w[5];
    logic [15:0] seen[$];
    bit sent, r;
    for (int i = 0; i < 5; i++) begin
      w[i] = rand_ins(32);
      step(1, w[i], 0, 0, 0);
      if (i == 3) begin
        n_cmp++;
        if ({ready_o, stall_o} !== 2'b01) begin
          n_fail++; $display("FAIL fill_full_flags: got ready=%b stall=%b expected ready=0 stall=1", ready_o, stall_o);
        end
      end
    end
    o = dut_out(); e = model_out(); n_cmp++;
    if (o !== e) begin n_fail++; $display("FAIL fill_fifth_blocked: got %h expected %h", o, e); end
    sent = 0;
    for (int k = 0; k < 12; k++) begin
      r = m_ready;
      if (valid_o) seen.push_back(imm_o);
      step(!sent, w[4], 1, 0, 0);
      if (r) sent = 1;
      o = dut_out(); e = model_out(); n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL drain_cycle%0d: got %h expected %h", k, o, e); end
    end
    n_cmp++;
    if (!sent || seen.size() != 5) begin
      n_fail++; $display("FAIL drain_count: got sent=%0d popped=%0d expected sent=1 popped=5", sent, seen.size());
    end else
      for (int i = 0; i < 5; i++) begin
        n_cmp++;
        if (seen[i] !== w[i][15:0]) begin
          n_fail++; $display("FAIL drain_order%0d: got %h expected %h", i, seen[i], w[i][15:0]);
        end
      end
  endtask

  task automatic test_drop();
    int d0, c0;
    d0 = m_drop; c0 = m_dec;
    step(1, 32'h7C000000, 1, 0, 0);
    n_cmp++;
    if ({valid_o, droppedCount_o, decodedCount_o} !== {1'b0, 16'(d0 + 1), 16'(c0)}) begin
      n_fail++;
      $display("FAIL drop_op31: got v=%b drop=%0d dec=%0d expected v=0 drop=%0d dec=%0d",
               valid_o, droppedCount_o, decodedCount_o, d0 + 1, c0);
    end
  endtask

  task automatic test_flush();
    int d0, c0;
    for (int i = 0; i < 4; i++) step(1, rand_ins(14), 0, 0, 0);
    d0 = m_drop; c0 = m_dec;
    step(1, 32'h3861FFFC, 1, 1, 0);
    n_cmp++;
    if ({valid_o, ready_o, stall_o, decodedCount_o, droppedCount_o} !== {3'b010, 16'(c0), 16'(d0)}) begin
      n_fail++;
      $display("FAIL flush_full: got v=%b rdy=%b stall=%b dec=%0d drop=%0d expected v=0 rdy=1 stall=0 dec=%0d drop=%0d",
               valid_o, ready_o, stall_o, decodedCount_o, droppedCount_o, c0, d0);
    end
  endtask

  task automatic test_fp();
    int d0;
    d0 = m_drop;
    step(1, 32'hC0A30010, 1, 0, 0);
    n_cmp++;
    if (FP) begin
      if ({valid_o, opcode_o, reg1Use_o, reg2Use_o, reg2ValOrZero_o} !== {1'b1, 6'd48, 2'd2, 2'd1, 1'b1}) begin
        n_fail++; $display("FAIL fp_lfs_enqueue: got v=%b op=%0d use=%0d,%0d z=%b expected v=1 op=48 use=2,1 z=1",
                           valid_o, opcode_o, reg1Use_o, reg2Use_o, reg2ValOrZero_o);
      end
    end else begin
      if ({valid_o, droppedCount_o} !== {1'b0, 16'(d0 + 1)}) begin
        n_fail++; $display("FAIL fp_lfs_drop: got v=%b drop=%0d expected v=0 drop=%0d", valid_o, droppedCount_o, d0 + 1);
      end
    end
    step(0, '0, 1, 0, 0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 24; i++) begin
      step(1, rand_ins($urandom_range(2, 15)), 1, 0, 0);
      o = dut_out(); e = model_out(); n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL b2b_cycle%0d: got %h expected %h", i, o, e); end
    end
    step(0, '0, 1, 0, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 3) != 0, rand_ins($urandom_range(0, 63)), $urandom_range(0, 1) == 1,
           $urandom_range(0, 31) == 0, 1'b0);
      o = dut_out(); e = model_out(); n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL random_cycle%0d: got %h expected %h", i, o, e); end
    end
  endtask

  task automatic test_reset_mid_burst();
    out_t z;
    for (int i = 0; i < 3; i++) step(1, rand_ins(36), 0, 0, 0);
    step(1, rand_ins(14), 1, 1, 1);
    z = '0; z.ready = 1'b1;
    o = dut_out(); n_cmp++;
    if (o !== z) begin n_fail++; $display("FAIL reset_mid_burst: got %h expected %h", o, z); end
  endtask

  task automatic test_saturation();
    step(0, '0, 0, 0, 1);
    for (int i = 0; i < SAT + 4; i++) step(1, rand_ins(14), 1, 0, 0);
    n_cmp++;
    if (decodedCount_o !== 16'hFFFF) begin
      n_fail++; $display("FAIL decoded_saturate: got %h expected ffff", decodedCount_o);
    end
    o = dut_out(); e = model_out(); n_cmp++;
    if (o !== e) begin n_fail++; $display("FAIL saturate_state: got %h expected %h", o, e); end
    test_reset_mid_burst();
  endtask

  initial begin
    test_reset();
    test_addi();
    test_fill_drain();
    test_drop();
    test_flush();
    test_fp();
    test_back_to_back();
    test_random();
    test_reset();
    test_reset_mid_burst();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
